// File: rtl/multi_wave_tone_generator.sv
// rtl/multi_wave_tone_generator.sv - four-waveform tone source with linear ASR envelope and 3-cycle output pipeline
module multi_wave_tone_generator #(
    parameter int PHASE_W      = 32,
    parameter int LUT_ADDR_W   = 6,
    parameter int OUT_W        = 8,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic [PHASE_W-1:0] phase_incr_in,
    input  logic [1:0]         wave_sel_in,
    input  logic [2:0]         vol_shift_in,
    input  logic               gate_in,
    output logic [OUT_W-1:0]   amp_out,
    output logic               valid_out,
    output logic               active_out
);

    localparam int LUT_DEPTH   = 2 ** LUT_ADDR_W;
    localparam int PROD_W      = OUT_W + ENV_W + 1;
    localparam int AMP_MAX_INT = 2 ** (OUT_W - 1) - 1;
    localparam int FRAC        = 28;
    localparam longint TWO_PI_Q = 64'sd1686629713;

    localparam logic signed [OUT_W-1:0] AMP_MAX = OUT_W'(AMP_MAX_INT);
    localparam logic signed [OUT_W-1:0] AMP_MIN = OUT_W'(-AMP_MAX_INT);
    localparam logic [ENV_W-1:0]        ENV_MAX = '1;
    localparam logic [ENV_W:0]          ATK     = (ENV_W + 1)'(ATTACK_STEP);
    localparam logic [ENV_W:0]          RLS     = (ENV_W + 1)'(RELEASE_STEP);

    typedef logic signed [OUT_W-1:0] lut_t [LUT_DEPTH];

    // Quarter-wave Taylor series in Q28 fixed point, folded to the full period.
    function automatic lut_t gen_sine_lut();
        lut_t   lut;
        longint x, term, sum, val;
        int     j;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            j = k % (LUT_DEPTH / 2);
            if (j > LUT_DEPTH / 4) j = LUT_DEPTH / 2 - j;
            x    = (longint'(j) * TWO_PI_Q) / longint'(LUT_DEPTH);
            term = x;
            sum  = x;
            for (int n = 1; n <= 7; n++) begin
                term = -((((term * x) >>> FRAC) * x) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
                sum  = sum + term;
            end
            val = (longint'(AMP_MAX_INT) * sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
            lut[k] = (k >= LUT_DEPTH / 2) ? OUT_W'(-val) : OUT_W'(val);
        end
        return lut;
    endfunction

    localparam lut_t SINE_LUT = gen_sine_lut();

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [ENV_W-1:0]    env_q, env_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;

    logic                s0_valid_q;
    logic [PHASE_W-1:0]  s0_phase_q;
    logic [ENV_W-1:0]    s0_env_q;
    logic [1:0]          s0_wave_q;
    logic [2:0]          s0_vol_q;

    logic                s1_valid_q;
    logic signed [OUT_W-1:0] s1_raw_q, raw_d;
    logic [ENV_W-1:0]    s1_env_q;
    logic [2:0]          s1_vol_q;

    logic                valid_q;
    logic signed [OUT_W-1:0] amp_q, amp_d;

    logic [ENV_W:0]      env_up;
    logic [ENV_W-1:0]    env_up_sat, env_dn_sat;
    logic [OUT_W-1:0]    saw_seg, tri_seg;
    logic signed [PROD_W-1:0] raw_ext, env_ext, prod, scaled;

    always_comb begin
        phase_d    = step_in ? phase_q + phase_incr_in : phase_q;
        state_d    = state_q;
        env_d      = env_q;
        env_up     = {1'b0, env_q} + ATK;
        env_up_sat = (env_up >= {1'b0, ENV_MAX}) ? ENV_MAX : env_up[ENV_W-1:0];
        env_dn_sat = ({1'b0, env_q} <= RLS) ? '0 : env_q - RLS[ENV_W-1:0];
        if (step_in) begin
            case (state_q)
                ST_SUSTAIN: begin
                    if (!gate_in) begin
                        env_d   = env_dn_sat;
                        state_d = (env_dn_sat == '0) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    // Gate from IDLE/ATTACK/RELEASE ramps up from wherever env currently sits.
                    if (gate_in) begin
                        env_d   = env_up_sat;
                        state_d = (env_up_sat == ENV_MAX) ? ST_SUSTAIN : ST_ATTACK;
                    end else if (state_q == ST_ATTACK) begin
                        state_d = ST_RELEASE;
                    end else if (state_q == ST_RELEASE) begin
                        env_d   = env_dn_sat;
                        state_d = (env_dn_sat == '0) ? ST_IDLE : ST_RELEASE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        saw_seg = s0_phase_q[PHASE_W-1 -: OUT_W];
        tri_seg = s0_phase_q[PHASE_W-2 -: OUT_W] ^ {OUT_W{s0_phase_q[PHASE_W-1]}};
        case (s0_wave_q)
            2'd0:    raw_d = SINE_LUT[s0_phase_q[PHASE_W-1 -: LUT_ADDR_W]];
            2'd1:    raw_d = s0_phase_q[PHASE_W-1] ? AMP_MIN : AMP_MAX;
            2'd2:    raw_d = {~saw_seg[OUT_W-1], saw_seg[OUT_W-2:0]};
            default: raw_d = {~tri_seg[OUT_W-1], tri_seg[OUT_W-2:0]};
        endcase
    end

    always_comb begin
        raw_ext = PROD_W'(s1_raw_q);
        env_ext = PROD_W'(s1_env_q);
        prod    = raw_ext * env_ext;
        scaled  = (prod >>> ENV_W) >>> s1_vol_q;
        amp_d   = scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            env_q      <= '0;
            phase_q    <= '0;
            s0_valid_q <= 1'b0;
            s0_phase_q <= '0;
            s0_env_q   <= '0;
            s0_wave_q  <= '0;
            s0_vol_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_env_q   <= '0;
            s1_vol_q   <= '0;
            valid_q    <= 1'b0;
            amp_q      <= '0;
        end else begin
            state_q    <= state_d;
            env_q      <= env_d;
            phase_q    <= phase_d;
            s0_valid_q <= step_in;
            if (step_in) begin
                s0_phase_q <= phase_q;
                s0_env_q   <= env_q;
                s0_wave_q  <= wave_sel_in;
                s0_vol_q   <= vol_shift_in;
            end
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_raw_q <= raw_d;
                s1_env_q <= s0_env_q;
                s1_vol_q <= s0_vol_q;
            end
            valid_q <= s1_valid_q;
            if (s1_valid_q) amp_q <= amp_d;
        end
    end

    assign amp_out    = amp_q;
    assign valid_out  = valid_q;
    assign active_out = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_wave_tone_generator.sv
// tb/tb_multi_wave_tone_generator.sv - scoreboard bench for multi_wave_tone_generator
module tb_multi_wave_tone_generator;

    localparam int AS = 64;
    localparam int RS = 32;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_in = 1'b0;
    logic [31:0] phase_incr_in = '0;
    logic [1:0]  wave_sel_in = '0;
    logic [2:0]  vol_shift_in = '0;
    logic        gate_in = 1'b0;
    logic [7:0]  amp_out;
    logic        valid_out;
    logic        active_out;

    multi_wave_tone_generator #(
        .PHASE_W(32), .LUT_ADDR_W(6), .OUT_W(8), .ENV_W(8),
        .ATTACK_STEP(AS), .RELEASE_STEP(RS)
    ) dut (
        .clk_in(clk), .rst_in(rst), .step_in(step_in),
        .phase_incr_in(phase_incr_in), .wave_sel_in(wave_sel_in),
        .vol_shift_in(vol_shift_in), .gate_in(gate_in),
        .amp_out(amp_out), .valid_out(valid_out), .active_out(active_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int amp;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    longint m_phase = 0;
    int     m_env   = 0;
    bit     m_gated_up = 0;   // envelope has reached full scale and is holding
    bit     m_falling  = 0;   // gate dropped while envelope was non-zero

    function automatic int floordiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int raw_of(longint p, int w);
        int  q;
        real x;
        case (w)
            0: begin
                x = 127.0 * $sin(2.0 * PI * real'(p >> 26) / 64.0);
                return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
            end
            1: return (p < 64'h8000_0000) ? 127 : -127;
            2: return int'(p >> 24) - 128;
            default: begin
                q = int'((p >> 23) & 255);
                if (p >= 64'h8000_0000) q = 255 - q;
                return q - 128;
            end
        endcase
    endfunction

    function automatic bit model_active();
        return (m_env != 0) || (!m_falling && m_gated_up) || (!m_falling && m_env != 0);
    endfunction

    bit m_active = 0;

    task automatic model_reset();
        m_phase = 0; m_env = 0; m_gated_up = 0; m_falling = 0; m_active = 0;
    endtask

    // Envelope rules: gate high ramps up to 255 and holds; gate low ramps down to 0.
    // A gate drop during the ramp-up freezes env for that one step.
    task automatic model_env(input bit g);
        if (g) begin
            if (m_env < 255 || !m_active) begin
                m_env = (m_env + AS > 255) ? 255 : m_env + AS;
            end
            m_active = 1;
            m_falling = 0;
            m_gated_up = (m_env == 255);
        end else if (m_active) begin
            if (!m_gated_up && !m_falling) begin
                m_falling = 1;
            end else begin
                m_env = (m_env - RS < 0) ? 0 : m_env - RS;
                m_falling = 1;
                m_gated_up = 0;
                if (m_env == 0) m_active = 0;
            end
        end
    endtask

    task automatic do_step(input logic [31:0] incr, input int w, input int vol, input bit g);
        exp_t e;
        @(negedge clk);
        step_in = 1'b1; phase_incr_in = incr; wave_sel_in = w[1:0];
        vol_shift_in = vol[2:0]; gate_in = g;
        e.amp = floordiv(floordiv(raw_of(m_phase, w) * m_env, 256), 1 << vol);
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        m_phase = (m_phase + longint'(incr)) & 64'hFFFF_FFFF;
        model_env(g);
        @(posedge clk);
        #1;
        step_in = 1'b0;
        checks++;
        if (active_out !== m_active) begin
            errors++;
            $display("FAIL active_out got %0b expected %0b at cycle %0d", active_out, m_active, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (amp_out !== 8'd0 || valid_out !== 1'b0 || active_out !== 1'b0) begin
            errors++;
            $display("FAIL %s got amp=%0d valid=%0b active=%0b expected 0 0 0",
                     tag, amp_out, valid_out, active_out);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && valid_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got amp=%0d with nothing expected", $signed(amp_out));
                end else begin
                    e = exp_q.pop_front();
                    if (int'($signed(amp_out)) != e.amp || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sample got amp=%0d cyc=%0d expected amp=%0d cyc=%0d",
                                 $signed(amp_out), cyc, e.amp, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #1;
        check_zero_outputs("reset_outputs");
        idle(2);
        rst = 1'b0;
        model_reset();
        idle(1);

        // square at half rate, attack into sustain, then attenuated
        for (int i = 0; i < 8; i++) do_step(32'h8000_0000, 1, 0, 1);
        for (int i = 0; i < 6; i++) do_step(32'h8000_0000, 1, 3, 1);
        // full saw cycle with wrap, then sine through all table quadrants
        for (int i = 0; i < 260; i++) do_step(32'h0100_0000, 2, 0, 1);
        for (int i = 0; i < 70; i++) do_step(32'h0400_0000, 0, 0, 1);
        for (int i = 0; i < 40; i++) do_step(32'h0080_0000, 3, 0, 1);
        // release to idle with gaps between steps
        for (int i = 0; i < 10; i++) begin
            do_step(32'h8000_0000, 1, 0, 0);
            if (i % 3 == 0) idle(2);
        end
        // re-gate in release at env 159
        for (int i = 0; i < 5; i++) do_step(32'h8000_0000, 1, 0, 1);
        for (int i = 0; i < 3; i++) do_step(32'h8000_0000, 1, 0, 0);
        for (int i = 0; i < 4; i++) do_step(32'h8000_0000, 1, 0, 1);
        // gate drop during attack freezes env for one step
        for (int i = 0; i < 8; i++) do_step(32'h8000_0000, 1, 0, 0);
        do_step(32'h8000_0000, 1, 0, 1);
        for (int i = 0; i < 3; i++) do_step(32'h8000_0000, 1, 0, 0);
        for (int i = 0; i < 6; i++) do_step(32'h8000_0000, 1, 0, 1);

        // asynchronous reset between edges while samples are in flight
        for (int i = 0; i < 3; i++) do_step(32'h4000_0000, 1, 0, 1);
        @(negedge clk);
        step_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        step_in = 1'b0;
        exp_q.delete();
        model_reset();
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) do_step(32'h2000_0000, 3, 0, 1);

        // randomized controls
        for (int i = 0; i < 500; i++) begin
            logic [31:0] incr;
            bit g;
            g = (i % 40) < 25;
            if ($urandom_range(0, 15) == 0) g = ~g;
            incr = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            do_step(incr, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), g);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d samples outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
